// File: rtl/cla_sub_seq.sv
// Slice-serial subtractor: diff = a - b - bin, one 4-bit carry-lookahead slice per clock, LSB first.
// Optional signed saturation on overflow when CLA_SUB_SAT_EN is defined.
module cla_sub_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NumSlices = WIDTH / 4;
  localparam int unsigned CntW = (NumSlices > 1) ? $clog2(NumSlices) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NumSlices - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             bout_d, ovf_d, zero_d, in_ready_d, out_valid_d;

  logic [3:0]       a_k, nb_k, p, g, sum;
  logic [4:0]       c;
  logic [CntW+1:0]  shamt;
  logic [WIDTH-1:0] diff_fin;
  logic             ovf_fin;

  // Current slice: a + ~b + carry, with the registered carry as c0.
  always_comb begin
    shamt    = {cnt_q, 2'b00};
    a_k      = 4'(a_q >> shamt);
    nb_k     = ~4'(b_q >> shamt);
    p        = a_k ^ nb_k;
    g        = a_k & nb_k;
    c[0]     = carry_q;
    c[1]     = g[0] | (p[0] & c[0]);
    c[2]     = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3]     = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4]     = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
    sum      = p ^ c[3:0];
    diff_fin = (diff & ~(WIDTH'(4'hf) << shamt)) | (WIDTH'(sum) << shamt);
    ovf_fin  = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_fin[WIDTH-1] != a_q[WIDTH-1]);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    diff_d  = diff;
    bout_d  = bout;
    ovf_d   = ovf;
    zero_d  = zero;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = ~bin;
          cnt_d   = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        diff_d  = diff_fin;
        carry_d = c[4];
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          cnt_d   = '0;
          bout_d  = ~c[4];
          ovf_d   = ovf_fin;
`ifdef CLA_SUB_SAT_EN
          if (ovf_fin) begin
            diff_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
          end
`endif
          zero_d  = (diff_d == '0);
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    in_ready_d  = (state_d == StIdle);
    out_valid_d = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b1;
      cnt_q     <= '0;
      diff      <= '0;
      bout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      carry_q   <= carry_d;
      cnt_q     <= cnt_d;
      diff      <= diff_d;
      bout      <= bout_d;
      ovf       <= ovf_d;
      zero      <= zero_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_cla_sub_seq.sv
// Directed, table-driven bench for cla_sub_seq (WIDTH=16), plus hand-written corner sequences.
module tb_cla_sub_seq;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, bin, out_valid, out_ready;
  logic [W-1:0] a, b, diff;
  logic         bout, ovf, zero;

  int checks = 0;
  int errors = 0;

  cla_sub_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    logic         zero;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present operands at a falling edge; returns #1 after the accepting edge.
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bv_in);
    @(negedge clk);
    a        = av;
    b        = bv;
    bin      = bv_in;
    in_valid = 1'b1;
    chk("in_ready_before_accept", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts edges until out_valid; the bound keeps a stuck DUT from hanging the run.
  task automatic wait_done(input bit scramble, output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      chk("in_ready_busy", in_ready, 0);
      if (scramble) begin
        @(negedge clk);
        a   = W'($urandom);
        b   = W'($urandom);
        bin = 1'($urandom);
      end
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic handoff();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("out_valid_after_handoff", out_valid, 0);
    chk("in_ready_after_handoff", in_ready, 1);
  endtask

  task automatic check_result(input vec_t v, input int lat, input string tag);
    chk({tag, "_latency"}, lat, 4);
    chk({tag, "_out_valid"}, out_valid, 1);
    chk({tag, "_diff"}, diff, v.diff);
    chk({tag, "_bout"}, bout, v.bout);
    chk({tag, "_ovf"}, ovf, v.ovf);
    chk({tag, "_zero"}, zero, v.zero);
  endtask

  initial begin
    int   lat;
    vec_t v;
    vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
`ifdef CLA_SUB_SAT_EN
    vecs[2] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
`else
    vecs[2] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
`endif
    vecs[3] = '{16'h5555, 16'h5554, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_zero", zero, 0);
    @(negedge clk);
    rst = 1'b0;

    // out_ready while idle must be ignored.
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("idle_out_ready_in_ready", in_ready, 1);
    chk("idle_out_ready_out_valid", out_valid, 0);

    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      start_op(v.a, v.b, v.bin);
      chk("out_valid_after_accept", out_valid, 0);
      wait_done(1'b0, lat);
      check_result(v, lat, $sformatf("vec%0d", i));
      handoff();
    end

    // Operands scrambled during CALC must not affect the result.
    v = vecs[3];
    start_op(v.a, v.b, v.bin);
    wait_done(1'b1, lat);
    check_result(v, lat, "scramble");
    handoff();

    // Back-pressure: results hold for 5 cycles in DONE.
    v = vecs[7];
    start_op(v.a, v.b, v.bin);
    wait_done(1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_result(v, 4, $sformatf("hold%0d", i));
      chk("hold_in_ready", in_ready, 0);
    end
    handoff();

    // Reset during the second CALC cycle aborts asynchronously.
    v = vecs[0];
    start_op(16'h7FFF, 16'hFFFF, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_diff", diff, 0);
    chk("midrst_bout", bout, 0);
    chk("midrst_ovf", ovf, 0);
    chk("midrst_zero", zero, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("midrst_hold_out_valid", out_valid, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("postrst_out_valid", out_valid, 0);
      chk("postrst_in_ready", in_ready, 1);
    end
    start_op(v.a, v.b, v.bin);
    wait_done(1'b0, lat);
    check_result(v, lat, "postrst");
    handoff();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
